// File: rtl/sprite_map_writer.sv
// Read-modify-write sprite mover on port B of the tile-map RAM: restores the tile
// under a sprite's old cell, saves the tile at its new cell and draws the sprite there.
module sprite_map_writer #(
   parameter int             N_SPR      = 3,
   parameter int             COLS       = 40,
   parameter int             ROWS       = 30,
   parameter int             TW         = 4,
   parameter int             XW         = 6,
   parameter int             YW         = 5,
   parameter int             RD_LAT     = 1,
   parameter logic [TW-1:0]  EMPTY_CODE = '0
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic [N_SPR-1:0]      req,
   input  logic [N_SPR*TW-1:0]   spr_code,
   input  logic [N_SPR*XW-1:0]   curr_x,
   input  logic [N_SPR*XW-1:0]   next_x,
   input  logic [N_SPR*YW-1:0]   curr_y,
   input  logic [N_SPR*YW-1:0]   next_y,
   output logic [N_SPR-1:0]      ack,
   output logic                  err,
   output logic                  busy,
   output logic [YW-1:0]         wraddr,
   output logic [COLS*TW-1:0]    wrdata,
   output logic                  wren,
   input  logic [COLS*TW-1:0]    redata
);

   localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
   localparam int CW = $clog2(RD_LAT + 1);
   localparam int RW = COLS * TW;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_OLD, S_WR_OLD, S_RD_NEW, S_WR_NEW, S_ACK
   } state_t;

   typedef struct packed {
      logic [IW-1:0] sel;
      logic [TW-1:0] code;
      logic [XW-1:0] cx;
      logic [YW-1:0] cy;
      logic [XW-1:0] nx;
      logic [YW-1:0] ny;
   } job_t;

   state_t            r_state;
   job_t              r_job;
   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_last;
   logic [TW-1:0]     r_underlay [N_SPR];
   logic [N_SPR-1:0]  r_placed;
   logic [N_SPR-1:0]  r_ack;
   logic              r_err;
   logic              r_busy;
   logic [YW-1:0]     r_wraddr;
   logic [RW-1:0]     r_wrdata;
   logic              r_wren;

   logic [IW-1:0]     w_gidx;
   logic              w_gvalid;
   job_t              w_job;
   logic              w_placed;
   logic              w_same;
   logic              w_err;
   logic              w_rd_done;

   // Column 0 sits in the most significant nibble of the row word.
   function automatic logic [TW-1:0] get_col(input logic [RW-1:0] row, input logic [XW-1:0] x);
      get_col = '0;
      for (int c = 0; c < COLS; c++)
         if (int'(x) == c) get_col = row[RW-1-TW*c -: TW];
   endfunction

   function automatic logic [RW-1:0] put_col(input logic [RW-1:0] row, input logic [XW-1:0] x,
                                             input logic [TW-1:0] code);
      put_col = row;
      for (int c = 0; c < COLS; c++)
         if (int'(x) == c) put_col[RW-1-TW*c -: TW] = code;
   endfunction

   function automatic logic [N_SPR-1:0] onehot(input logic [IW-1:0] s);
      onehot    = '0;
      onehot[s] = 1'b1;
   endfunction

   // Round-robin search from r_last+1; scanning downwards lets the nearest requester win.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      int v_idx;
      w_gvalid = 1'b0;
      w_gidx   = '0;
      for (int off = N_SPR; off >= 1; off--) begin
         v_idx = int'(r_last) + off;
         if (v_idx >= N_SPR) v_idx = v_idx - N_SPR;
         if (req[v_idx]) begin
            w_gvalid = 1'b1;
            w_gidx   = IW'(v_idx);
         end
      end
   end

   always_comb begin
      w_job.sel  = w_gidx;
      w_job.code = spr_code[int'(w_gidx)*TW +: TW];
      w_job.cx   = curr_x[int'(w_gidx)*XW +: XW];
      w_job.cy   = curr_y[int'(w_gidx)*YW +: YW];
      w_job.nx   = next_x[int'(w_gidx)*XW +: XW];
      w_job.ny   = next_y[int'(w_gidx)*YW +: YW];
   end

   // Old coordinates only matter once the sprite is on the map.
   assign w_placed  = r_placed[w_gidx];
   assign w_same    = (w_job.cx == w_job.nx) && (w_job.cy == w_job.ny);
   assign w_err     = (int'(w_job.nx) >= COLS) || (int'(w_job.ny) >= ROWS) ||
                      (w_placed && ((int'(w_job.cx) >= COLS) || (int'(w_job.cy) >= ROWS)));
   assign w_rd_done = (r_cnt == CW'(RD_LAT));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_job    <= '0;
         r_cnt    <= '0;
         r_last   <= IW'(N_SPR - 1);
         r_placed <= '0;
         r_ack    <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         r_wraddr <= '0;
         r_wrdata <= '0;
         r_wren   <= 1'b0;
         // NOTE: the underlay file is tiny and must read EMPTY_CODE after reset, so it is reset like any register.
         for (int i = 0; i < N_SPR; i++) r_underlay[i] <= EMPTY_CODE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gvalid) begin
                  r_last <= w_gidx;
                  r_job  <= w_job;
                  r_busy <= 1'b1;
                  r_cnt  <= '0;
                  if (w_err) begin
                     r_ack   <= onehot(w_gidx);
                     r_err   <= 1'b1;
                     r_state <= S_ACK;
                  end else if (w_placed && w_same) begin
                     r_ack   <= onehot(w_gidx);
                     r_state <= S_ACK;
                  end else if (!w_placed) begin
                     r_wraddr <= w_job.ny;
                     r_state  <= S_RD_NEW;
                  end else begin
                     r_wraddr <= w_job.cy;
                     r_state  <= S_RD_OLD;
                  end
               end
            end
            S_RD_OLD: begin
               if (w_rd_done) begin
                  r_wrdata <= put_col(redata, r_job.cx, r_underlay[r_job.sel]);
                  r_wren   <= 1'b1;
                  r_state  <= S_WR_OLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WR_OLD: begin
               r_wren   <= 1'b0;
               r_wraddr <= r_job.ny;
               r_cnt    <= '0;
               r_state  <= S_RD_NEW;
            end
            S_RD_NEW: begin
               if (w_rd_done) begin
                  r_underlay[r_job.sel] <= get_col(redata, r_job.nx);
                  r_placed[r_job.sel]   <= 1'b1;
                  r_wrdata              <= put_col(redata, r_job.nx, r_job.code);
                  r_wren                <= 1'b1;
                  r_state               <= S_WR_NEW;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WR_NEW: begin
               r_wren  <= 1'b0;
               r_ack   <= onehot(r_job.sel);
               r_state <= S_ACK;
            end
            S_ACK: begin
               r_ack   <= '0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ack    = r_ack;
   assign err    = r_err;
   assign busy   = r_busy;
   assign wraddr = r_wraddr;
   assign wrdata = r_wrdata;
   assign wren   = r_wren;

endmodule

// File: tb/tb_sprite_map_writer.sv
// Directed bench for sprite_map_writer with a behavioural 1-cycle-latency map RAM.
// Vector table covers placement, moves, no-move and errors; hand sequences cover the rest.
module tb_sprite_map_writer;

   localparam int N_SPR  = 3;
   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int TW     = 4;
   localparam int XW     = 6;
   localparam int YW     = 5;
   localparam int RD_LAT = 1;
   localparam int RW     = COLS * TW;

   logic                 CLOCK_50 = 1'b0;
   logic                 reset;
   logic [N_SPR-1:0]     req;
   logic [N_SPR*TW-1:0]  spr_code;
   logic [N_SPR*XW-1:0]  curr_x, next_x;
   logic [N_SPR*YW-1:0]  curr_y, next_y;
   logic [N_SPR-1:0]     ack;
   logic                 err, busy, wren;
   logic [YW-1:0]        wraddr;
   logic [RW-1:0]        wrdata, redata;

   logic                 load;
   logic [RW-1:0]        mem [ROWS];
   logic [RW-1:0]        rd_q;

   int total = 0;
   int bad   = 0;

   sprite_map_writer #(
      .N_SPR(N_SPR), .COLS(COLS), .ROWS(ROWS), .TW(TW), .XW(XW), .YW(YW),
      .RD_LAT(RD_LAT), .EMPTY_CODE(4'h0)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .spr_code(spr_code),
      .curr_x(curr_x), .next_x(next_x), .curr_y(curr_y), .next_y(next_y),
      .ack(ack), .err(err), .busy(busy), .wraddr(wraddr), .wrdata(wrdata),
      .wren(wren), .redata(redata)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Row words built column by column from the MSB end; col=-1 yields a uniform row.
   function automatic logic [RW-1:0] row_with(input logic [TW-1:0] base, input int col,
                                              input logic [TW-1:0] code);
      logic [RW-1:0] r;
      r = '0;
      for (int c = 0; c < COLS; c++) r = {r[RW-TW-1:0], (c == col) ? code : base};
      return r;
   endfunction

   always @(posedge CLOCK_50) begin
      if (load) begin
         for (int r = 0; r < ROWS; r++) mem[r] <= row_with((r == 10) ? 4'h5 : 4'h1, -1, 4'h0);
      end else if (int'(wraddr) < ROWS) begin
         rd_q <= mem[wraddr];
         if (wren) mem[wraddr] <= wrdata;
      end
   end
   assign redata = rd_q;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_spr(input int s, input logic [TW-1:0] code, input int cx, input int cy,
                          input int nx, input int ny);
      spr_code[s*TW +: TW] = code;
      curr_x[s*XW +: XW]   = XW'(cx);
      curr_y[s*YW +: YW]   = YW'(cy);
      next_x[s*XW +: XW]   = XW'(nx);
      next_y[s*YW +: YW]   = YW'(ny);
   endtask

   int                o_nwr, o_ack_cyc;
   int                o_wc [2];
   logic [YW-1:0]     o_wa [2];
   logic [RW-1:0]     o_wd [2];
   logic [N_SPR-1:0]  o_ackv;
   logic              o_err, o_busy1;

   // Cycle n is observed at the n-th falling edge after the granting edge k.
   task automatic run_op(input int s, input int drop_at);
      o_nwr = 0; o_ack_cyc = -1; o_ackv = '0; o_err = 1'b0; o_busy1 = 1'b0;
      o_wc[0] = -1; o_wc[1] = -1; o_wa[0] = '0; o_wa[1] = '0; o_wd[0] = '0; o_wd[1] = '0;
      @(negedge CLOCK_50);
      req[s] = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge CLOCK_50);
         if (n == 1) o_busy1 = busy;
         if (n == drop_at) req[s] = 1'b0;
         if (wren) begin
            if (o_nwr < 2) begin
               o_wc[o_nwr] = n; o_wa[o_nwr] = wraddr; o_wd[o_nwr] = wrdata;
            end
            o_nwr++;
         end
         if (ack != '0) begin
            o_ack_cyc = n; o_ackv = ack; o_err = err;
            req[s] = 1'b0;
            break;
         end
      end
      req[s] = 1'b0;
   endtask

   typedef struct {
      int             sel;
      logic [TW-1:0]  code;
      int             cx, cy, nx, ny;
      logic           exp_err;
      int             exp_nwr;
      int             exp_ack;
      logic [YW-1:0]  a1;
      logic [RW-1:0]  d1;
      logic [YW-1:0]  a2;
      logic [RW-1:0]  d2;
   } vec_t;

   function automatic vec_t mk(input int sel, input logic [TW-1:0] code, input int cx, input int cy,
                               input int nx, input int ny, input logic e, input int nwr, input int ak,
                               input int a1, input logic [RW-1:0] d1, input int a2, input logic [RW-1:0] d2);
      vec_t v;
      v.sel = sel; v.code = code; v.cx = cx; v.cy = cy; v.nx = nx; v.ny = ny;
      v.exp_err = e; v.exp_nwr = nwr; v.exp_ack = ak;
      v.a1 = YW'(a1); v.d1 = d1; v.a2 = YW'(a2); v.d2 = d2;
      return v;
   endfunction

   vec_t vecs [8];
   int   rr_got [6];
   int   n_rr;
   int   n_ack;
   logic [N_SPR-1:0] pend, ev;

   initial begin
      vecs[0] = mk(0, 4'hA,  0,  0,  5,  3, 1'b0, 1, 4,  3, row_with(4'h1,  5, 4'hA),  0, '0);
      vecs[1] = mk(0, 4'hA,  5,  3,  6,  3, 1'b0, 2, 7,  3, row_with(4'h1, -1, 4'h0),  3, row_with(4'h1,  6, 4'hA));
      vecs[2] = mk(1, 4'hC,  0,  0,  6, 10, 1'b0, 1, 4, 10, row_with(4'h5,  6, 4'hC),  0, '0);
      vecs[3] = mk(1, 4'hC,  6, 10,  6, 10, 1'b0, 0, 1,  0, '0,                        0, '0);
      vecs[4] = mk(2, 4'hE,  0,  0, 40,  0, 1'b1, 0, 1,  0, '0,                        0, '0);
      vecs[5] = mk(2, 4'hE,  0,  0,  0,  0, 1'b0, 1, 4,  0, row_with(4'h1,  0, 4'hE),  0, '0);
      vecs[6] = mk(1, 4'hC,  6, 10, 39, 29, 1'b0, 2, 7, 10, row_with(4'h5, -1, 4'h0), 29, row_with(4'h1, 39, 4'hC));
      vecs[7] = mk(0, 4'hA,  6, 30,  6,  3, 1'b1, 0, 1,  0, '0,                        0, '0);

      reset = 1'b1; load = 1'b1; req = '0;
      spr_code = '0; curr_x = '0; curr_y = '0; next_x = '0; next_y = '0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_ack",    RW'(ack),    '0);
      check("rst_err",    RW'(err),    '0);
      check("rst_busy",   RW'(busy),   '0);
      check("rst_wren",   RW'(wren),   '0);
      check("rst_wraddr", RW'(wraddr), '0);
      check("rst_wrdata", wrdata,      '0);
      reset = 1'b0; load = 1'b0;

      for (int i = 0; i < 8; i++) begin
         set_spr(vecs[i].sel, vecs[i].code, vecs[i].cx, vecs[i].cy, vecs[i].nx, vecs[i].ny);
         run_op(vecs[i].sel, 0);
         ev = '0; ev[vecs[i].sel] = 1'b1;
         check($sformatf("v%0d_ack_cyc", i), RW'(o_ack_cyc), RW'(vecs[i].exp_ack));
         check($sformatf("v%0d_ack_vec", i), RW'(o_ackv), RW'(ev));
         check($sformatf("v%0d_err", i),     RW'(o_err), RW'(vecs[i].exp_err));
         check($sformatf("v%0d_nwr", i),     RW'(o_nwr), RW'(vecs[i].exp_nwr));
         check($sformatf("v%0d_busy", i),    RW'(o_busy1), RW'(1));
         if (vecs[i].exp_nwr >= 1) begin
            check($sformatf("v%0d_wr1_cyc", i),  RW'(o_wc[0]), RW'(3));
            check($sformatf("v%0d_wr1_addr", i), RW'(o_wa[0]), RW'(vecs[i].a1));
            check($sformatf("v%0d_wr1_data", i), o_wd[0], vecs[i].d1);
         end
         if (vecs[i].exp_nwr == 2) begin
            check($sformatf("v%0d_wr2_cyc", i),  RW'(o_wc[1]), RW'(6));
            check($sformatf("v%0d_wr2_addr", i), RW'(o_wa[1]), RW'(vecs[i].a2));
            check($sformatf("v%0d_wr2_data", i), o_wd[1], vecs[i].d2);
         end
      end
      @(negedge CLOCK_50);
      check("idle_busy", RW'(busy), '0);
      check("map_row3", mem[3], row_with(4'h1, 6, 4'hA));

      // Request dropped one cycle after grant still runs to a single ack.
      set_spr(1, 4'hC, 39, 29, 38, 29);
      run_op(1, 1);
      check("drop_ack_cyc",  RW'(o_ack_cyc), RW'(7));
      check("drop_ack_vec",  RW'(o_ackv), RW'(3'b010));
      check("drop_nwr",      RW'(o_nwr), RW'(2));
      check("drop_wr1_data", o_wd[0], row_with(4'h1, -1, 4'h0));
      check("drop_wr2_addr", RW'(o_wa[1]), RW'(29));
      check("drop_wr2_data", o_wd[1], row_with(4'h1, 38, 4'hC));
      n_ack = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge CLOCK_50);
         if (ack != '0) n_ack++;
      end
      check("drop_extra_ack", RW'(n_ack), '0);

      // Sprite 2 goes last so the round-robin pass starts at sprite 0.
      set_spr(0, 4'hA,  6,  3,  6,  3);
      set_spr(1, 4'hC, 38, 29, 38, 29);
      set_spr(2, 4'hE,  0,  0,  0,  0);
      run_op(2, 0);
      check("nomove2_ack_cyc", RW'(o_ack_cyc), RW'(1));
      check("nomove2_nwr",     RW'(o_nwr), '0);

      n_rr = 0; pend = '0;
      @(negedge CLOCK_50);
      req = '1;
      for (int n = 0; n < 200 && n_rr < 6; n++) begin
         @(negedge CLOCK_50);
         req = req | pend;
         pend = '0;
         if (ack != '0) begin
            check($sformatf("rr%0d_onehot", n_rr), RW'($countones(ack)), RW'(1));
            for (int i = 0; i < N_SPR; i++) if (ack[i]) rr_got[n_rr] = i;
            n_rr++;
            req = req & ~ack;
            pend = ack;
            if (n_rr == 6) req = '0;
         end
      end
      req = '0;
      check("rr_count", RW'(n_rr), RW'(6));
      for (int i = 0; i < 6; i++)
         if (i < n_rr) check($sformatf("rr%0d_order", i), RW'(rr_got[i]), RW'(i % 3));

      // Reset during WR_NEW: outputs clear next cycle, no ack, and the sprite forgets placement.
      repeat (2) @(negedge CLOCK_50);
      set_spr(0, 4'hA, 6, 3, 7, 3);
      req[0] = 1'b1;
      n_ack = 0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge CLOCK_50);
         if (ack != '0) n_ack++;
         if (n == 6) begin
            check("rst_mid_wren_before", RW'(wren), RW'(1));
            reset = 1'b1;
            req[0] = 1'b0;
         end
         if (n == 7) begin
            check("rst_mid_wren", RW'(wren), '0);
            check("rst_mid_busy", RW'(busy), '0);
         end
         if (n == 8) reset = 1'b0;
      end
      check("rst_mid_no_ack", RW'(n_ack), '0);
      set_spr(0, 4'hA, 7, 3, 8, 3);
      run_op(0, 0);
      check("post_rst_nwr",     RW'(o_nwr), RW'(1));
      check("post_rst_ack_cyc", RW'(o_ack_cyc), RW'(4));
      check("post_rst_addr",    RW'(o_wa[0]), RW'(3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_map_writer.md
# sprite_map_writer

Parametrised read-modify-write engine that moves up to `N_SPR` sprites (Pac-Man plus ghosts) through the tile-map RAM. It owns port B of the map RAM, which is shared with the VGA read path on port A. For each granted move request it restores the tile that was under the sprite at its old cell, saves the tile at the new cell, and draws the sprite code there. Move requests from the Pac-Man and ghost location controllers are arbitrated round-robin, and each is completed with a per-sprite ack pulse.

## Interface
- `N_SPR`, 3: number of sprite channels.
- `COLS`, 40: tiles per map row.
- `ROWS`, 30: map rows.
- `TW`, 4: bits per tile code.
- `XW`, 6: x coordinate width.
- `YW`, 5: y coordinate width.
- `RD_LAT`, 1: RAM read latency in cycles, from address to valid `redata`; must be ≥1.
- `EMPTY_CODE`, 0: underlay value after reset.

Ports:
- `CLOCK_50` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req` in `N_SPR`: per-sprite move request, level; held until the matching `ack`.
- `spr_code` in `N_SPR*TW`: tile code drawn for sprite i, at slice [i*TW +: TW].
- `curr_x` / `next_x` in `N_SPR*XW`: old and new column per sprite.
- `curr_y` / `next_y` in `N_SPR*YW`: old and new row per sprite.
- `ack` out `N_SPR`: one-cycle completion pulse for sprite i.
- `err` out 1: pulses together with `ack` when the request was rejected.
- `busy` out 1: high in every state except IDLE.
- `wraddr` out `YW`: RAM port B address, used for both read and write.
- `wrdata` out `COLS*TW`: row word to write.
- `wren` out 1: RAM port B write enable.
- `redata` in `COLS*TW`: RAM port B read data.

## Operation
- Column x occupies bits [COLS*TW-1-TW*x -: TW] of a row word, so column 0 is in the MSBs.
- Per-sprite state:
  - `underlay[i]` (TW bits): the tile currently hidden under sprite i.
  - `placed[i]` (1 bit): whether sprite i has been drawn yet.
- On grant, the block latches `curr_x`, `curr_y`, `next_x`, `next_y` and `spr_code` for the winner. Changing these inputs mid-operation has no effect.
- Arbitration is round-robin starting from `last+1`. `last` resets to `N_SPR-1`, so sprite 0 has first priority. `last` updates at grant.
- Request classification at grant:
  - **Error:** any coordinate with x≥COLS or y≥ROWS. Go to ACK with `err`=1, make no writes, leave state unchanged.
  - **No move:** `placed`=1 and curr==next. Go to ACK, make no writes.
  - **First placement:** `placed`=0. Skip the restore phase; `curr_*` is ignored.
  - **Normal move:** full sequence.
- State sequence: IDLE → RD_OLD → WR_OLD → RD_NEW → WR_NEW → ACK → IDLE.
  - RD_OLD: `wraddr`=curr_y, held for RD_LAT+1 cycles.
  - WR_OLD: `wrdata` = `redata` with column curr_x replaced by `underlay[i]`; `wren`=1.
  - RD_NEW: `wraddr`=next_y, held for RD_LAT+1 cycles.
  - WR_NEW: capture `underlay[i]` = `redata` at column next_x; `wrdata` = `redata` with column next_x set to `spr_code[i]`; `wren`=1; set `placed[i]`=1.
- Old and new cells in the same row work correctly, because RD_NEW re-reads the row after WR_OLD has written it.
- If `req[i]` drops before `ack`, the operation still completes. `ack` is not re-issued until a new request.

## Timing
- Reset values:
  - state IDLE; `ack`=0, `err`=0, `busy`=0, `wren`=0, `wraddr`=0, `wrdata`=0.
  - all `underlay`=EMPTY_CODE, all `placed`=0, `last`=N_SPR-1.
- Let k be the edge at which `req` is sampled in IDLE.
- Normal move:
  - `wren` is high in cycle k+RD_LAT+2 and in cycle k+2·RD_LAT+4.
  - `ack` is high in cycle k+2·RD_LAT+5.
  - With RD_LAT=1: writes at k+3 and k+6, ack at k+7.
- First placement: single write at k+RD_LAT+2; `ack` at k+RD_LAT+3.
- No move or error: `ack` at k+1, `wren` never asserted.
- After ACK, IDLE lasts at least one cycle. Back-to-back grants are therefore spaced by at least 1 cycle after `ack`.
- `wren` is high for exactly one cycle per write. `wrdata` and `wraddr` are stable in that cycle.
- Reset asserted mid-operation:
  - next cycle is IDLE with all outputs at reset values; no `ack` for the aborted request.
  - a half-written RAM row is not repaired (the map is reloaded by the game reset).
- Simultaneous requests are served one at a time in round-robin order. There are no simultaneous acks.

## Test plan
- **Reset.** Assert `reset` for 2 cycles mid-WR_NEW → `wren`=0 and `busy`=0 the next cycle; a subsequent request for the same sprite is treated as a first placement.
- **First placement.** Sprite 0, `spr_code`=4'hA, next=(5,3); row 3 reads 0x1 in all columns → exactly one write, `wraddr`=3, column 5 = A, other columns 1; `underlay[0]`=1; ack at k+4.
- **Normal move in the same row.** Sprite 0 at (5,3) moves to (6,3) → write 1 restores column 5 to 1; write 2 sets column 6 to A with column 5 still 1; ack at k+7.
- **Round-robin.** `req`=3'b111 held; each requester drops its `req` after its `ack` and re-raises it immediately → ack order 0,1,2,0,1,2.
- **No move and error.** Placed sprite 1 with curr==next → ack at k+1, no `wren`. Sprite 2 with next_x=40 → ack and `err` at k+1, no `wren`, `placed[2]` unchanged.
- **Request dropped early.** Deassert `req[1]` one cycle after grant → the full write sequence still completes and one `ack[1]` pulse is issued.
